// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, state encoding and port ids for the memory arbiter
package mem_arbiter_pkg;

    localparam int MEM_AW = 9;
    localparam int MEM_DW = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rtl/mem_arbiter_rr_pick2.sv - two-requester winner selection, round-robin or fixed priority
module rr_pick2
    import mem_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = PORT_CPU;
        if (req0 && req1) begin
            // on a tie, round-robin hands the grant to whichever port did not win last
            winner = FIXED_PRIO ? PORT_CPU : ~last_grant;
        end else if (req1) begin
            winner = PORT_LDR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the single-port main memory between CPU and loader ports
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = MEM_AW,
    parameter int DW         = MEM_DW,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          gnt_id
);

    arb_state_t state;
    logic       last_grant;
    logic       pick_valid;
    logic       pick_id;

    rr_pick2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .winner     (pick_id)
    );

    // last_grant resets to the loader port so the CPU wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wr     <= 1'b0;
            gnt_id     <= 1'b0;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        mem_addr   <= pick_id ? addr1  : addr0;
                        mem_wdata  <= pick_id ? wdata1 : wdata0;
                        mem_wr     <= pick_id ? we1    : we0;
                        gnt_id     <= pick_id;
                        last_grant <= pick_id;
                        busy       <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // memory registered its output on the falling edge of this cycle
                    mem_wr <= 1'b0;
                    if (gnt_id == PORT_LDR) begin
                        rdata1 <= mem_rdata;
                        ack1   <= 1'b1;
                    end else begin
                        rdata0 <= mem_rdata;
                        ack0   <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter, round-robin and fixed-priority instances
module tb_mem_arbiter;

    localparam int NCYC = 600;

    typedef struct packed {
        logic        we;
        logic [8:0]  addr;
        logic [11:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst;

    logic        req0[2], we0[2], req1[2], we1[2];
    logic [8:0]  addr0[2], addr1[2];
    logic [11:0] wdata0[2], wdata1[2];
    logic        ack0[2], ack1[2], mem_wr[2], busy[2], gnt_id[2];
    logic [11:0] rdata0[2], rdata1[2], mem_wdata[2], mem_rdata[2];
    logic [8:0]  mem_addr[2];

    logic [11:0] mem[2][512];
    logic [11:0] ref_mem[2][512];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // instance 0 is round-robin, instance 1 is fixed priority
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.AW(9), .DW(12), .FIXED_PRIO(g == 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req0      (req0[g]),
            .we0       (we0[g]),
            .addr0     (addr0[g]),
            .wdata0    (wdata0[g]),
            .ack0      (ack0[g]),
            .rdata0    (rdata0[g]),
            .req1      (req1[g]),
            .we1       (we1[g]),
            .addr1     (addr1[g]),
            .wdata1    (wdata1[g]),
            .ack1      (ack1[g]),
            .rdata1    (rdata1[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wr    (mem_wr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g]),
            .gnt_id    (gnt_id[g])
        );
    end

    function automatic logic [11:0] init_val(input int a);
        case (a)
            0:       return 12'o1006;
            1:       return 12'o0100;
            2:       return 12'o7000;
            6:       return 12'o0002;
            default: return 12'(a * 743 + 35);
        endcase
    endfunction

    // memory: output registered on the falling edge, old content returned on a write
    initial begin
        for (int i = 0; i < 2; i++) begin
            mem_rdata[i] = '0;
            for (int a = 0; a < 512; a++) mem[i][a] = init_val(a);
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (mem_addr[i] !== 9'bx) begin
                    mem_rdata[i] = mem[i][mem_addr[i]];
                    if (mem_wr[i] === 1'b1) mem[i][mem_addr[i]] = mem_wdata[i];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    req_t q00[$];
    req_t q01[$];

    function automatic bit scripted(input int i, input int p);
        if (i != 0) return 1'b0;
        return (p == 0) ? (q00.size() > 0) : (q01.size() > 0);
    endfunction

    function automatic req_t next_req(input int i, input int p);
        req_t r;
        if (i == 0 && p == 0 && q00.size() > 0) return q00.pop_front();
        if (i == 0 && p == 1 && q01.size() > 0) return q01.pop_front();
        r.we    = ($urandom_range(2) == 0);
        r.addr  = ($urandom_range(1) == 1) ? 9'($urandom_range(15)) : 9'($urandom_range(511));
        r.wdata = 12'($urandom);
        return r;
    endfunction

    function automatic logic port_req(input int i, input int p);
        return (p == 0) ? req0[i] : req1[i];
    endfunction

    function automatic req_t fields(input int i, input logic p);
        req_t r;
        if (p == 1'b0) r = '{we: we0[i], addr: addr0[i], wdata: wdata0[i]};
        else           r = '{we: we1[i], addr: addr1[i], wdata: wdata1[i]};
        return r;
    endfunction

    task automatic set_port(input int i, input int p, input logic a, input req_t r);
        if (p == 0) begin
            req0[i] = a; we0[i] = r.we; addr0[i] = r.addr; wdata0[i] = r.wdata;
        end else begin
            req1[i] = a; we1[i] = r.we; addr1[i] = r.addr; wdata1[i] = r.wdata;
        end
    endtask

    function automatic logic pick(input logic r0, input logic r1, input logic lg, input bit fixed);
        if (r0 && r1) return fixed ? 1'b0 : ~lg;
        return r1;
    endfunction

    // transaction-level reference: a grant at sample cycle g means ack at g+1, next sample at g+3
    int          free_at[2], g_cyc[2], served[2][2];
    bit          has[2];
    logic        t_port[2], last[2], exp_gnt[2];
    req_t        txn[2];
    logic [11:0] exp_rd[2][2];

    initial begin
        bit in_acc, in_rsp, found;
        int mism;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_port(i, 0, 1'b0, '0);
            set_port(i, 1, 1'b0, '0);
            free_at[i] = 0; has[i] = 1'b0; last[i] = 1'b1; exp_gnt[i] = 1'b0;
            exp_rd[i][0] = '0; exp_rd[i][1] = '0;
            served[i][0] = 0; served[i][1] = 0;
            for (int a = 0; a < 512; a++) ref_mem[i][a] = init_val(a);
        end
        q00.push_back('{we: 1'b0, addr: 9'd6, wdata: 12'o0});
        q00.push_back('{we: 1'b0, addr: 9'd0, wdata: 12'o0});
        q00.push_back('{we: 1'b0, addr: 9'd1, wdata: 12'o0});
        q00.push_back('{we: 1'b0, addr: 9'd2, wdata: 12'o0});
        q01.push_back('{we: 1'b1, addr: 9'o100, wdata: 12'o7000});
        q01.push_back('{we: 1'b0, addr: 9'o100, wdata: 12'o0});

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_busy", busy[i], 0);
            check("reset_mem_wr", mem_wr[i], 0);
            check("reset_ack", {ack0[i], ack1[i]}, 0);
            check("reset_gnt", gnt_id[i], 0);
            check("reset_addr", mem_addr[i], 0);
            check("reset_rdata", {rdata0[i], rdata1[i]}, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++)
                if (scripted(i, p) || $urandom_range(1) == 1) set_port(i, p, 1'b1, next_req(i, p));

        for (int k = 0; k < NCYC; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (k >= free_at[i] && (req0[i] || req1[i])) begin
                    t_port[i]  = pick(req0[i], req1[i], last[i], i == 1);
                    last[i]    = t_port[i];
                    exp_gnt[i] = t_port[i];
                    txn[i]     = fields(i, t_port[i]);
                    g_cyc[i]   = k;
                    has[i]     = 1'b1;
                    free_at[i] = k + 3;
                end
                in_acc = has[i] && k == g_cyc[i];
                in_rsp = has[i] && k == g_cyc[i] + 1;
                check("busy", busy[i], in_acc || in_rsp);
                check("mem_wr", mem_wr[i], in_acc && txn[i].we);
                check("gnt_id", gnt_id[i], exp_gnt[i]);
                if (in_acc) begin
                    check("mem_addr", mem_addr[i], txn[i].addr);
                    check("mem_wdata", mem_wdata[i], txn[i].wdata);
                end
                check("ack0", ack0[i], in_rsp && t_port[i] == 1'b0);
                check("ack1", ack1[i], in_rsp && t_port[i] == 1'b1);
                if (in_rsp) begin
                    exp_rd[i][t_port[i]] = ref_mem[i][txn[i].addr];
                    if (txn[i].we) ref_mem[i][txn[i].addr] = txn[i].wdata;
                    served[i][t_port[i]]++;
                end
                check("rdata0", rdata0[i], exp_rd[i][0]);
                check("rdata1", rdata1[i], exp_rd[i][1]);
            end
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    if (port_req(i, p) && has[i] && k == g_cyc[i] + 1 && t_port[i] == p[0]) begin
                        if (scripted(i, p) || $urandom_range(3) != 0)
                            set_port(i, p, 1'b1, next_req(i, p));
                        else
                            set_port(i, p, 1'b0, fields(i, p[0]));
                    end else if (!port_req(i, p) && $urandom_range(2) == 0) begin
                        set_port(i, p, 1'b1, next_req(i, p));
                    end
                end
            end
        end

        check("rr_port0_served", served[0][0] > 0, 1);
        check("rr_port1_served", served[0][1] > 0, 1);
        check("fixed_port0_served", served[1][0] > 0, 1);

        for (int i = 0; i < 2; i++) begin
            set_port(i, 0, 1'b0, '0);
            set_port(i, 1, 1'b0, '0);
        end
        repeat (4) @(posedge clk);
        #1;
        set_port(0, 0, 1'b1, '{we: 1'b1, addr: 9'd3, wdata: 12'o1234});
        found = 1'b0;
        for (int n = 0; n < 6 && !found; n++) begin
            @(posedge clk);
            #1;
            found = (mem_wr[0] === 1'b1);
        end
        check("rst_mid_access_reached", found, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_access_mem_wr", mem_wr[0], 0);
        check("rst_mid_access_busy", busy[0], 0);
        set_port(0, 0, 1'b0, '0);
        @(negedge clk);
        #1;
        check("rst_mid_access_mem3", mem[0][3], ref_mem[0][3]);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            check("post_rst_ack", {ack0[0], ack1[0]}, 0);
            check("post_rst_busy", busy[0], 0);
        end

        for (int i = 0; i < 2; i++) begin
            mism = 0;
            for (int a = 0; a < 512; a++) if (mem[i][a] !== ref_mem[i][a]) mism++;
            check("final_memory", mism, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
